// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N-to-1 round-robin stream multiplexer.
package stream_mux_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping at N_CH.
module rr_arbiter #(
   parameter int unsigned N_CH = 4,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   always_comb begin
      int unsigned idx;
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      idx       = 0;
      // Offset 1 first, so the previous winner has lowest priority.
      for (int unsigned off = 1; off <= N_CH; off++) begin
         idx = (32'(ptr) + off) % N_CH;
         if (!gnt_valid && req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SEL_W'(idx);
            gnt[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with fixed or round-robin arbitration, packet locking
// and a single registered output stage.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH-1:0]       in_last,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   output logic                  out_last,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   input  logic                  out_ready
);

   lock_state_e      state_q, state_d;
   logic [SEL_W-1:0] lock_ch_q;
   logic [SEL_W-1:0] rr_ptr_q;

   logic             locked;
   logic             can_load;
   logic             grant_valid;
   logic [SEL_W-1:0] grant_idx;
   logic [N_CH-1:0]  grant_oh;
   logic [N_CH-1:0]  arb_gnt;
   logic [SEL_W-1:0] arb_idx;
   logic             arb_valid;
   logic             xfer;
   logic             xfer_last;

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   assign can_load = !out_valid || out_ready;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_oh    = '0;
      if (locked) begin
         grant_valid = 1'b1;
         grant_idx   = lock_ch_q;
         grant_oh[lock_ch_q] = 1'b1;
      end else if (mode == MODE_RR) begin
         grant_valid = arb_valid;
         grant_idx   = arb_idx;
         grant_oh    = arb_gnt;
      end else if (32'(sel) < N_CH) begin
         grant_valid = 1'b1;
         grant_idx   = sel;
         grant_oh[sel] = 1'b1;
      end
   end

   // Nothing is offered upstream while reset is held.
   assign in_ready  = (can_load && !rst) ? grant_oh : '0;
   assign xfer      = |(in_valid & in_ready);
   assign xfer_last = grant_valid && in_last[grant_idx];

   // Lock FSM: state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         lock_ch_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && xfer) begin
            lock_ch_q <= grant_idx;
         end
      end
   end

   // Lock FSM: next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (xfer && !xfer_last) state_d = ST_LOCKED;
         ST_LOCKED: if (xfer && xfer_last)  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Lock FSM: outputs.
   always_comb begin
      locked = (state_q == ST_LOCKED);
   end

   // Pointer moves per packet, so fairness is counted in packets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= SEL_W'(N_CH - 1);
      end else if (xfer && xfer_last) begin
         rr_ptr_q <= grant_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_last  <= xfer_last;
         out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
         out_ch    <= grant_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed, table-driven bench for stream_mux_rr (N_CH=4 main instance, N_CH=3 for sel range).
module tb_stream_mux_rr;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic [31:0] dat;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [1:0]  e_ch;
      logic [7:0]  e_dat;
      logic        e_last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic        out_last;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_ready;

   logic        m3_mode;
   logic [1:0]  m3_sel;
   logic [2:0]  m3_valid;
   logic [2:0]  m3_last;
   logic [23:0] m3_data;
   logic [2:0]  m3_ready;
   logic        m3_ov;
   logic        m3_ol;
   logic [7:0]  m3_od;
   logic [1:0]  m3_och;
   logic        m3_ordy;

   int n_cmp  = 0;
   int n_fail = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   stream_mux_rr #(.N_CH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .mode      (m3_mode),
      .sel       (m3_sel),
      .in_valid  (m3_valid),
      .in_last   (m3_last),
      .in_data   (m3_data),
      .in_ready  (m3_ready),
      .out_valid (m3_ov),
      .out_last  (m3_ol),
      .out_data  (m3_od),
      .out_ch    (m3_och),
      .out_ready (m3_ordy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic [3:0] l, input logic [31:0] d, input logic r,
                      input logic [3:0] er, input logic eov, input logic [1:0] ech,
                      input logic [7:0] ed, input logic el);
      vec_t t;
      t.mode = m; t.sel = s; t.vld = v; t.lst = l; t.dat = d; t.ordy = r;
      t.e_rdy = er; t.e_ov = eov; t.e_ch = ech; t.e_dat = ed; t.e_last = el;
      vecs.push_back(t);
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_last = '0; in_data = '0;
      out_ready = 1'b0;
      m3_mode = 1'b0; m3_sel = 2'd3; m3_valid = '0; m3_last = '0; m3_data = 24'hC2B1A0;
      m3_ordy = 1'b1;

      // Round robin from reset: ch0 first, one beat per cycle.
      add(1, 0, 4'hF, 4'hF, 32'h44332211, 1, 4'b0001, 1, 0, 8'h11, 1);
      add(1, 0, 4'hF, 4'hF, 32'h44332211, 1, 4'b0010, 1, 1, 8'h22, 1);
      add(1, 0, 4'hF, 4'hF, 32'h44332211, 1, 4'b0100, 1, 2, 8'h33, 1);
      add(1, 0, 4'hF, 4'hF, 32'h44332211, 1, 4'b1000, 1, 3, 8'h44, 1);
      add(1, 0, 4'hF, 4'hF, 32'h44332211, 1, 4'b0001, 1, 0, 8'h11, 1);
      // Fixed select ch2; other channels never see ready.
      add(0, 2, 4'b0100, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 2, 8'hA5, 1);
      add(0, 2, 4'b1011, 4'b1011, 32'h44332211, 1, 4'b0100, 0, 0, 8'h00, 0);
      // Move pointer to ch0, then ch1 three-beat packet with ch0/ch2 competing.
      add(1, 0, 4'b0001, 4'b0001, 32'h44332211, 1, 4'b0001, 1, 0, 8'h11, 1);
      add(1, 0, 4'b0111, 4'b0000, 32'h0033A111, 1, 4'b0010, 1, 1, 8'hA1, 0);
      add(0, 3, 4'b0111, 4'b0000, 32'h0033A211, 1, 4'b0010, 1, 1, 8'hA2, 0);
      add(1, 0, 4'b0111, 4'b0010, 32'h0033A311, 1, 4'b0010, 1, 1, 8'hA3, 1);
      add(1, 0, 4'b0101, 4'b0101, 32'h00330011, 1, 4'b0100, 1, 2, 8'h33, 1);
      // Backpressure for five cycles, then drain and load together.
      for (int i = 0; i < 5; i++)
         add(1, 0, 4'hF, 4'hF, 32'h44332211, 0, 4'b0000, 1, 2, 8'h33, 1);
      add(1, 0, 4'hF, 4'hF, 32'h44332211, 1, 4'b1000, 1, 3, 8'h44, 1);
      add(1, 0, 4'h0, 4'h0, 32'h44332211, 1, 4'b0000, 0, 0, 8'h00, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset out_last", 32'(out_last), 0);
      chk("reset out_data", 32'(out_data), 0);
      chk("reset out_ch", 32'(out_ch), 0);
      chk("reset in_ready", 32'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[k]) begin
         mode = vecs[k].mode; sel = vecs[k].sel; in_valid = vecs[k].vld;
         in_last = vecs[k].lst; in_data = vecs[k].dat; out_ready = vecs[k].ordy;
         #1;
         chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vecs[k].e_ov));
         if (vecs[k].e_ov) begin
            chk($sformatf("v%0d out_ch", k), 32'(out_ch), 32'(vecs[k].e_ch));
            chk($sformatf("v%0d out_data", k), 32'(out_data), 32'(vecs[k].e_dat));
            chk($sformatf("v%0d out_last", k), 32'(out_last), 32'(vecs[k].e_last));
         end
      end

      // Reset in the middle of a ch2 packet.
      mode = 1'b1; in_valid = 4'b0100; in_last = 4'b0000; in_data = 32'h44332211;
      out_ready = 1'b1;
      #1;
      chk("midpkt in_ready", 32'(in_ready), 32'h4);
      @(posedge clk);
      #1;
      chk("midpkt out_ch", 32'(out_ch), 2);
      chk("midpkt out_valid", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid), 0);
      chk("async rst out_data", 32'(out_data), 0);
      chk("async rst out_ch", 32'(out_ch), 0);
      chk("async rst in_ready", 32'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 4'hF; in_last = 4'hF;
      #1;
      chk("post rst in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      chk("post rst out_ch", 32'(out_ch), 0);
      chk("post rst out_data", 32'(out_data), 32'h11);
      in_valid = 4'h0;

      // Out-of-range select on a 3-channel instance.
      m3_mode = 1'b0; m3_sel = 2'd3; m3_valid = 3'b111; m3_last = 3'b111;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("sel range in_ready", 32'(m3_ready), 0);
         @(posedge clk);
         #1;
         chk("sel range out_valid", 32'(m3_ov), 0);
      end
      m3_sel = 2'd2;
      #1;
      chk("sel2 in_ready", 32'(m3_ready), 32'h4);
      @(posedge clk);
      #1;
      chk("sel2 out_valid", 32'(m3_ov), 1);
      chk("sel2 out_ch", 32'(m3_och), 2);
      chk("sel2 out_data", 32'(m3_od), 32'hC2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
